// File: rtl/soc_gpio_pkg.sv
// Shared register map, decoded word index and bus access payload for soc_gpio_ctrl.
package soc_gpio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;

  localparam logic [ADDR_W-1:0] GPIO_ODR     = 8'h00;
  localparam logic [ADDR_W-1:0] GPIO_IDR     = 8'h04;
  localparam logic [ADDR_W-1:0] GPIO_OENR    = 8'h08;
  localparam logic [ADDR_W-1:0] GPIO_RIER    = 8'h0C;
  localparam logic [ADDR_W-1:0] GPIO_FIER    = 8'h10;
  localparam logic [ADDR_W-1:0] GPIO_ISR     = 8'h14;
  localparam logic [ADDR_W-1:0] GPIO_ODR_SET = 8'h18;
  localparam logic [ADDR_W-1:0] GPIO_ODR_CLR = 8'h1C;

  localparam logic [DATA_W-1:0] OENR_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_ODR     = GPIO_ODR[4:2],
    REG_IDR     = GPIO_IDR[4:2],
    REG_OENR    = GPIO_OENR[4:2],
    REG_RIER    = GPIO_RIER[4:2],
    REG_FIER    = GPIO_FIER[4:2],
    REG_ISR     = GPIO_ISR[4:2],
    REG_ODR_SET = GPIO_ODR_SET[4:2],
    REG_ODR_CLR = GPIO_ODR_CLR[4:2]
  } gpio_reg_t;

  typedef struct packed {
    logic              wr;
    logic              mapped;
    gpio_reg_t         idx;
    logic [DATA_W-1:0] wdata;
  } gpio_acc_t;

  // Anything outside the 8 aligned words of the block is unmapped.
  function automatic gpio_acc_t decode_acc(input logic we, input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] wdata);
    gpio_acc_t a;
    a.wr     = we;
    a.mapped = (addr[7:5] == 3'd0) && (addr[1:0] == 2'd0);
    a.idx    = gpio_reg_t'(addr[4:2]);
    a.wdata  = wdata;
    return a;
  endfunction

endpackage

// File: rtl/soc_gpio_debouncer.sv
// Per-bit 3-sample majority-free debounce filter, sampled on a divided tick.
module soc_gpio_debouncer
  import soc_gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sync_in,
  input  logic [DATA_W-1:0] idr,
  output logic [DATA_W-1:0] idr_nxt_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_DIV);

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick_c;
  logic [DATA_W-1:0] hist0, hist1, hist2;

  assign tick_c = (tick_cnt == CNT_W'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      hist0    <= '0;
      hist1    <= '0;
      hist2    <= '0;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
      if (tick_c) begin
        hist2 <= hist1;
        hist1 <= hist0;
        hist0 <= sync_in;
      end
    end
  end

  // All-ones forces 1, all-zeros forces 0, any disagreement keeps the current IDR.
  assign idr_nxt_c = (hist0 & hist1 & hist2) | (idr & (hist0 | hist1 | hist2));

endmodule

// File: rtl/soc_gpio_ctrl.sv
// Memory-mapped 32-bit GPIO controller; optional input debounce under SOC_GPIO_DEBOUNCE_EN.
module soc_gpio_ctrl
  import soc_gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  output logic              bus_gnt,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rvalid,
  output logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] gpio_dout,
  output logic [DATA_W-1:0] gpio_oe_n,
  input  logic [DATA_W-1:0] gpio_din,
  output logic              gpio_irq
);

  if (DEBOUNCE_DIV < 2) begin : g_div_chk
    $error("DEBOUNCE_DIV must be at least 2");
  end

  gpio_acc_t         acc_c;
  logic              wr_hit_c;
  logic [DATA_W-1:0] s1, s2, idr, idr_q, filt_c;
  logic [DATA_W-1:0] odr, oenr, rier, fier, isr;
  logic [DATA_W-1:0] rd_c, clr_c, rise_c, fall_c;

  assign bus_gnt  = bus_req;
  assign acc_c    = decode_acc(bus_we, bus_addr, bus_wdata);
  assign wr_hit_c = bus_req && acc_c.wr && acc_c.mapped;

`ifdef SOC_GPIO_DEBOUNCE_EN
  soc_gpio_debouncer #(
    .DEBOUNCE_DIV(DEBOUNCE_DIV)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .sync_in  (s2),
    .idr      (idr),
    .idr_nxt_c(filt_c)
  );
`else
  assign filt_c = s2;
`endif

  assign rise_c = idr & ~idr_q;
  assign fall_c = ~idr & idr_q;
  assign clr_c  = (wr_hit_c && acc_c.idx == REG_ISR) ? acc_c.wdata : '0;

  // Read mux; write-only and unmapped locations read as zero.
  always_comb begin
    rd_c = '0;
    if (acc_c.mapped) begin
      case (acc_c.idx)
        REG_ODR:  rd_c = odr;
        REG_IDR:  rd_c = idr;
        REG_OENR: rd_c = oenr;
        REG_RIER: rd_c = rier;
        REG_FIER: rd_c = fier;
        REG_ISR:  rd_c = isr;
        default:  rd_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      idr        <= '0;
      idr_q      <= '0;
      odr        <= '0;
      oenr       <= OENR_RST;
      rier       <= '0;
      fier       <= '0;
      isr        <= '0;
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      s1    <= gpio_din;
      s2    <= s1;
      idr   <= filt_c;
      idr_q <= idr;
      // New edges are OR-ed in after the clear so a same-cycle set survives.
      isr   <= (isr & ~clr_c) | (rise_c & rier) | (fall_c & fier);
      if (wr_hit_c) begin
        case (acc_c.idx)
          REG_ODR:     odr  <= acc_c.wdata;
          REG_OENR:    oenr <= acc_c.wdata;
          REG_RIER:    rier <= acc_c.wdata;
          REG_FIER:    fier <= acc_c.wdata;
          REG_ODR_SET: odr  <= odr | acc_c.wdata;
          REG_ODR_CLR: odr  <= odr & ~acc_c.wdata;
          default:     ;
        endcase
      end
      bus_rvalid <= bus_req;
      if (bus_req) begin
        bus_rdata <= acc_c.wr ? '0 : rd_c;
      end
    end
  end

  assign gpio_dout = odr;
  assign gpio_oe_n = oenr;
  assign gpio_irq  = |isr;

endmodule

// File: tb/tb_soc_gpio_ctrl.sv
// Directed bench for soc_gpio_ctrl; debounce steps run when SOC_GPIO_DEBOUNCE_EN is defined.
module tb_soc_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_dout;
  logic [31:0] gpio_oe_n;
  logic [31:0] gpio_din;
  logic        gpio_irq;

  int n_pass  = 0;
  int n_total = 0;

  soc_gpio_ctrl #(.DEBOUNCE_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata),
    .gpio_dout (gpio_dout),
    .gpio_oe_n (gpio_oe_n),
    .gpio_din  (gpio_din),
    .gpio_irq  (gpio_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    chk({tag, "_gnt"}, 32'(bus_gnt), 32'd1);
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    chk({tag, "_rdata"}, bus_rdata, 32'h0);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_req = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    chk({tag, "_rdata"}, bus_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; gpio_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_irq", 32'(gpio_irq), 32'd0);
    chk("rst_dout", gpio_dout, 32'h0);
    chk("rst_oe_n", gpio_oe_n, 32'hFFFF_FFFF);
    rst = 1'b0;

    bus_read(8'h08, 32'hFFFF_FFFF, "rd_oenr_rst");
    bus_read(8'h00, 32'h0, "rd_odr_rst");
    bus_read(8'h14, 32'h0, "rd_isr_rst");

    // Set/clear/readback
    bus_write(8'h00, 32'h0000_00F0, "wr_odr");
    bus_write(8'h18, 32'h0000_0001, "wr_odr_set");
    bus_write(8'h1C, 32'h0000_0010, "wr_odr_clr");
    chk("dout_e1", gpio_dout, 32'h0000_00E1);
    bus_read(8'h00, 32'h0000_00E1, "rd_odr");
    @(negedge clk);
    chk("hold_rvalid", 32'(bus_rvalid), 32'd0);
    chk("hold_rdata", bus_rdata, 32'h0000_00E1);
    bus_read(8'h18, 32'h0, "rd_odr_set");
    bus_read(8'h1C, 32'h0, "rd_odr_clr");
    bus_write(8'h08, 32'h0000_FFFF, "wr_oenr");
    chk("oe_n", gpio_oe_n, 32'h0000_FFFF);

    // Unmapped accesses
    bus_read(8'h20, 32'h0, "rd_unmap_20");
    bus_read(8'h02, 32'h0, "rd_unmap_02");
    bus_write(8'h24, 32'hFFFF_FFFF, "wr_unmap_24");
    bus_write(8'h21, 32'h0, "wr_unmap_21");
    bus_write(8'h0A, 32'h0, "wr_unmap_0a");
    chk("unmap_dout", gpio_dout, 32'h0000_00E1);
    chk("unmap_oe_n", gpio_oe_n, 32'h0000_FFFF);
    bus_read(8'h0C, 32'h0, "unmap_rier");

`ifndef SOC_GPIO_DEBOUNCE_EN
    // Rising-edge interrupt, three cycles of input latency
    bus_write(8'h0C, 32'h4, "wr_rier");
    gpio_din[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rise_irq_early", 32'(gpio_irq), 32'd0);
    @(negedge clk);
    chk("rise_irq", 32'(gpio_irq), 32'd1);
    bus_read(8'h14, 32'h4, "rd_isr_rise");
    bus_read(8'h04, 32'h4, "rd_idr");
    bus_write(8'h14, 32'h4, "w1c_isr");
    chk("w1c_irq", 32'(gpio_irq), 32'd0);
    gpio_din[2] = 1'b0;
    repeat (5) @(negedge clk);
    chk("fall_disabled_irq", 32'(gpio_irq), 32'd0);

    // Set beats clear on the same bit
    gpio_din[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("rise_bit0_masked", 32'(gpio_irq), 32'd0);
    bus_write(8'h10, 32'h1, "wr_fier");
    gpio_din[0] = 1'b0;
    repeat (2) @(negedge clk);
    bus_write(8'h14, 32'h1, "w1c_race");
    chk("race_irq", 32'(gpio_irq), 32'd1);
    bus_read(8'h14, 32'h1, "rd_isr_race");
    bus_write(8'h10, 32'h0, "wr_fier_off");
    bus_read(8'h14, 32'h1, "rd_isr_keep");
    bus_write(8'h14, 32'h1, "w1c_bit0");
    chk("clr_irq", 32'(gpio_irq), 32'd0);
`else
    // Debounce: short glitch rejected, stable level accepted
    bus_write(8'h0C, 32'h1, "wr_rier_db");
    gpio_din[0] = 1'b1;
    repeat (5) @(negedge clk);
    gpio_din[0] = 1'b0;
    repeat (20) @(negedge clk);
    bus_read(8'h04, 32'h0, "db_glitch_idr");
    chk("db_glitch_irq", 32'(gpio_irq), 32'd0);
    gpio_din[0] = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(8'h04, 32'h1, "db_stable_idr");
    chk("db_stable_irq", 32'(gpio_irq), 32'd1);
`endif

    // Reset during a request drops the response
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 8'h00; rst = 1'b1;
    @(negedge clk);
    bus_req = 1'b0;
    chk("rst_mid_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_mid_dout", gpio_dout, 32'h0);
    chk("rst_mid_oe_n", gpio_oe_n, 32'hFFFF_FFFF);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(bus_rvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
